// File: rtl/mcu_request_issuer.sv
// Core-side MCU request issuer: latches one read/write request, pulses the MCU code for one cycle,
// waits the MCU sequencing time, then returns read bytes with a done pulse. Optional: MCU_REQ_STATS_EN.
module mcu_request_issuer #(
  parameter int unsigned RD_DIFF_WAIT = 5,
  parameter int unsigned RD_SAME_WAIT = 2,
  parameter int unsigned WR_DIFF_WAIT = 4,
  parameter int unsigned WR_SAME_WAIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic        i_diff,
  input  logic [15:0] i_addr1,
  input  logic [15:0] i_addr2,
  input  logic [15:0] i_addr3,
  input  logic [15:0] i_addr4,
  input  logic [7:0]  i_wdata1,
  input  logic [7:0]  i_wdata2,
  input  logic [7:0]  i_wdata3,
  input  logic [7:0]  i_wdata4,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_rdata1,
  output logic [7:0]  o_rdata2,
  output logic [7:0]  o_rdata3,
  output logic [7:0]  o_rdata4,
  output logic [1:0]  o_read,
  output logic [1:0]  o_write,
  output logic [15:0] o_ar1,
  output logic [15:0] o_ar2,
  output logic [15:0] o_ar3,
  output logic [15:0] o_ar4,
  output logic [7:0]  o_dr1,
  output logic [7:0]  o_dr2,
  output logic [7:0]  o_dr3,
  output logic [7:0]  o_dr4,
  input  logic [7:0]  i_mdr1,
  input  logic [7:0]  i_mdr2,
  input  logic [7:0]  i_mdr3,
  input  logic [7:0]  i_mdr4,
`ifdef MCU_REQ_STATS_EN
  output logic [15:0] o_rd_count,
  output logic [15:0] o_wr_count,
`endif
  output logic [1:0]  o_dbg_state
);

  if (RD_DIFF_WAIT < 1 || RD_DIFF_WAIT > 15 || RD_SAME_WAIT < 1 || RD_SAME_WAIT > 15 ||
      WR_DIFF_WAIT < 1 || WR_DIFF_WAIT > 15 || WR_SAME_WAIT < 1 || WR_SAME_WAIT > 15) begin : g_bad_wait
    $error("mcu_request_issuer: wait parameters must lie in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_op;
  logic        r_diff;
  logic [3:0]  r_cnt;
  logic [3:0]  w_wait_val;
  logic        w_wait_last;

  always_comb begin
    w_wait_val = 4'(RD_DIFF_WAIT);
    case ({r_op, r_diff})
      2'b00:   w_wait_val = 4'(RD_SAME_WAIT);
      2'b01:   w_wait_val = 4'(RD_DIFF_WAIT);
      2'b10:   w_wait_val = 4'(WR_SAME_WAIT);
      default: w_wait_val = 4'(WR_DIFF_WAIT);
    endcase
  end

  assign w_wait_last = (r_state == S_WAIT) && (r_cnt == 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_wait_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request codes are decoded from state so an async reset clears them in the same cycle.
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_read      = (r_state == S_ISSUE && !r_op) ? {r_diff, 1'b1} : 2'b00;
  assign o_write     = (r_state == S_ISSUE &&  r_op) ? {r_diff, 1'b1} : 2'b00;
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 1'b0;
      r_diff   <= 1'b0;
      r_cnt    <= 4'd0;
      o_ar1    <= 16'd0;
      o_ar2    <= 16'd0;
      o_ar3    <= 16'd0;
      o_ar4    <= 16'd0;
      o_dr1    <= 8'd0;
      o_dr2    <= 8'd0;
      o_dr3    <= 8'd0;
      o_dr4    <= 8'd0;
      o_rdata1 <= 8'd0;
      o_rdata2 <= 8'd0;
      o_rdata3 <= 8'd0;
      o_rdata4 <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_op   <= i_op;
        r_diff <= i_diff;
        o_ar1  <= i_addr1;
        o_ar2  <= i_addr2;
        o_ar3  <= i_addr3;
        o_ar4  <= i_addr4;
        o_dr1  <= i_wdata1;
        o_dr2  <= i_wdata2;
        o_dr3  <= i_wdata3;
        o_dr4  <= i_wdata4;
      end
      if (r_state == S_ISSUE) r_cnt <= w_wait_val;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      // Capture on the edge into DONE so read bytes are valid alongside o_done.
      if (w_wait_last && !r_op) begin
        o_rdata1 <= i_mdr1;
        o_rdata2 <= i_mdr2;
        o_rdata3 <= i_mdr3;
        o_rdata4 <= i_mdr4;
      end
    end
  end

`ifdef MCU_REQ_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_count <= 16'd0;
      o_wr_count <= 16'd0;
    end else if (r_state == S_DONE) begin
      if (r_op) o_wr_count <= o_wr_count + 16'd1;
      else      o_rd_count <= o_rd_count + 16'd1;
    end
  end
`endif

endmodule
